// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding selects, load-use/redirect/memory-wait stall and flush control, with wait timing and saturating counters
module hazard_ctrl #(
  parameter int ADDR_WIDTH  = 5,
  parameter int NUM_SRC     = 2,
  parameter int CNT_WIDTH   = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC*ADDR_WIDTH-1:0] D_rs,
  input  logic [NUM_SRC-1:0]            D_rs_used,
  input  logic [NUM_SRC*ADDR_WIDTH-1:0] E_rs,
  input  logic [ADDR_WIDTH-1:0]         E_rd,
  input  logic                          E_RegWrite,
  input  logic                          E_is_load,
  input  logic                          E_PCSrc,
  input  logic [ADDR_WIDTH-1:0]         M_rd,
  input  logic                          M_RegWrite,
  input  logic                          M_is_load,
  input  logic [ADDR_WIDTH-1:0]         W_rd,
  input  logic                          W_RegWrite,
  input  logic                          M_mem_req,
  input  logic                          mem_ready,
  input  logic                          clear_counters,
  output logic [2*NUM_SRC-1:0]          fwd_sel,
  output logic                          F_stall,
  output logic                          D_stall,
  output logic                          E_stall,
  output logic                          M_stall,
  output logic                          D_flush,
  output logic                          E_flush,
  output logic                          W_bubble,
  output logic [CNT_WIDTH-1:0]          stall_cycles,
  output logic [CNT_WIDTH-1:0]          flush_events,
  output logic [CNT_WIDTH-1:0]          wait_cycles,
  output logic                          mem_timeout
);
  typedef enum logic {S_RUN, S_WAIT} state_t;
  state_t state, state_nx;
  logic [CNT_WIDTH-1:0] wait_cnt;
  logic [NUM_SRC-1:0] lu_hit;
  logic [2*NUM_SRC-1:0] fwd_raw;
  logic lu, mw;
  genvar i;
  generate
    for (i = 0; i < NUM_SRC; i++) begin : g_src
      logic [ADDR_WIDTH-1:0] ers;
      assign ers = E_rs[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign lu_hit[i] = D_rs_used[i] && E_rd != '0 && D_rs[i*ADDR_WIDTH +: ADDR_WIDTH] == E_rd;
      assign fwd_raw[2*i +: 2] = (M_RegWrite && !M_is_load && M_rd != '0 && M_rd == ers) ? 2'b01 :
                                 (W_RegWrite && W_rd != '0 && W_rd == ers) ? 2'b10 : 2'b00;
    end
  endgenerate
  assign lu = E_is_load && E_RegWrite && |lu_hit;
  assign mw = M_mem_req && !mem_ready;
  always_ff @(posedge clk)
    if (!rst) state <= S_RUN;
    else state <= state_nx;
  always_comb
    state_nx = state == S_RUN ? (mw ? S_WAIT : S_RUN) : ((mem_ready || !M_mem_req) ? S_RUN : S_WAIT);
  // Memory wait dominates; a redirect cancels the load-use hold since D is being flushed anyway.
  always_comb begin
    fwd_sel  = rst ? fwd_raw : '0;
    F_stall  = rst && (mw || (lu && !E_PCSrc));
    D_stall  = F_stall;
    E_stall  = rst && mw;
    M_stall  = E_stall;
    W_bubble = E_stall;
    D_flush  = !rst || (!mw && E_PCSrc);
    E_flush  = !rst || (!mw && (E_PCSrc || lu));
  end
  always_ff @(posedge clk)
    if (!rst || state_nx == S_RUN) wait_cnt <= '0;
    else if (state == S_WAIT && wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
  always_ff @(posedge clk)
    if (!rst || clear_counters) begin
      stall_cycles <= '0;
      flush_events <= '0;
      wait_cycles  <= '0;
      mem_timeout  <= 1'b0;
    end else begin
      if (F_stall && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
      if (E_PCSrc && !mw && flush_events != '1) flush_events <= flush_events + 1'b1;
      if (mw && wait_cycles != '1) wait_cycles <= wait_cycles + 1'b1;
      if (state == S_WAIT && wait_cnt == CNT_WIDTH'(MEM_TIMEOUT - 1)) mem_timeout <= 1'b1;
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of forwarding, stalls, flushes, wait timing and counters
module tb_hazard_ctrl;
  logic clk = 1'b0, rst;
  logic [9:0] D_rs, E_rs;
  logic [1:0] D_rs_used;
  logic [4:0] E_rd, M_rd, W_rd;
  logic E_RegWrite, E_is_load, E_PCSrc, M_RegWrite, M_is_load, W_RegWrite;
  logic M_mem_req, mem_ready, clear_counters;
  logic [3:0] fwd_sel;
  logic F_stall, D_stall, E_stall, M_stall, D_flush, E_flush, W_bubble, mem_timeout;
  logic [3:0] stall_cycles, flush_events, wait_cycles;
  int tests = 0, fails = 0;

  hazard_ctrl #(.ADDR_WIDTH(5), .NUM_SRC(2), .CNT_WIDTH(4), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .D_rs(D_rs), .D_rs_used(D_rs_used), .E_rs(E_rs), .E_rd(E_rd),
    .E_RegWrite(E_RegWrite), .E_is_load(E_is_load), .E_PCSrc(E_PCSrc),
    .M_rd(M_rd), .M_RegWrite(M_RegWrite), .M_is_load(M_is_load),
    .W_rd(W_rd), .W_RegWrite(W_RegWrite), .M_mem_req(M_mem_req), .mem_ready(mem_ready),
    .clear_counters(clear_counters), .fwd_sel(fwd_sel), .F_stall(F_stall), .D_stall(D_stall),
    .E_stall(E_stall), .M_stall(M_stall), .D_flush(D_flush), .E_flush(E_flush), .W_bubble(W_bubble),
    .stall_cycles(stall_cycles), .flush_events(flush_events), .wait_cycles(wait_cycles),
    .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    D_rs = '0; E_rs = '0; D_rs_used = '0; E_rd = '0; M_rd = '0; W_rd = '0;
    E_RegWrite = 0; E_is_load = 0; E_PCSrc = 0; M_RegWrite = 0; M_is_load = 0; W_RegWrite = 0;
    M_mem_req = 0; mem_ready = 0; clear_counters = 0;
  endtask

  task automatic test_reset;
    idle();
    rst = 0;
    M_RegWrite = 1; M_rd = 5; E_rs = {5'd0, 5'd5}; M_mem_req = 1;
    #1;
    tests++; if (fwd_sel !== 4'b0000) begin fails++; $display("FAIL reset_fwd got %b exp 0000", fwd_sel); end
    tests++; if ({F_stall, E_stall, W_bubble} !== 3'b000) begin fails++; $display("FAIL reset_stall got %b exp 000", {F_stall, E_stall, W_bubble}); end
    tests++; if ({D_flush, E_flush} !== 2'b11) begin fails++; $display("FAIL reset_flush got %b exp 11", {D_flush, E_flush}); end
    tick();
    tick();
    tests++; if ({stall_cycles, flush_events, wait_cycles, mem_timeout} !== 13'd0) begin fails++; $display("FAIL reset_cnt got %h exp 0", {stall_cycles, flush_events, wait_cycles, mem_timeout}); end
    idle();
    rst = 1;
    tick();
  endtask

  task automatic test_forward;
    idle();
    M_RegWrite = 1; M_rd = 5; W_RegWrite = 1; W_rd = 5; E_rs = {5'd0, 5'd5};
    #1;
    tests++; if (fwd_sel !== 4'b0001) begin fails++; $display("FAIL fwd_m_over_w got %b exp 0001", fwd_sel); end
    M_RegWrite = 0;
    #1;
    tests++; if (fwd_sel !== 4'b0010) begin fails++; $display("FAIL fwd_w got %b exp 0010", fwd_sel); end
    M_RegWrite = 1; M_is_load = 1;
    #1;
    tests++; if (fwd_sel !== 4'b0010) begin fails++; $display("FAIL fwd_m_load got %b exp 0010", fwd_sel); end
    M_is_load = 0; M_rd = 0; W_rd = 0; E_rs = '0;
    #1;
    tests++; if (fwd_sel !== 4'b0000) begin fails++; $display("FAIL fwd_x0 got %b exp 0000", fwd_sel); end
    M_rd = 7; W_rd = 9; E_rs = {5'd7, 5'd9};
    #1;
    tests++; if (fwd_sel !== 4'b0110) begin fails++; $display("FAIL fwd_two_src got %b exp 0110", fwd_sel); end
    tick();
  endtask

  task automatic test_load_use;
    idle();
    E_is_load = 1; E_RegWrite = 1; E_rd = 6; D_rs = {5'd6, 5'd0}; D_rs_used = 2'b10;
    #1;
    tests++; if ({F_stall, D_stall, E_flush, D_flush, E_stall} !== 5'b11100) begin fails++; $display("FAIL lu_resp got %b exp 11100", {F_stall, D_stall, E_flush, D_flush, E_stall}); end
    tick();
    tests++; if (stall_cycles !== 4'd1) begin fails++; $display("FAIL lu_stall_cnt got %0d exp 1", stall_cycles); end
    idle();
    W_RegWrite = 1; W_rd = 6; E_rs = {5'd6, 5'd0};
    #1;
    tests++; if (fwd_sel[3:2] !== 2'b10 || F_stall !== 1'b0) begin fails++; $display("FAIL lu_then_fwd got %b/%b exp 10/0", fwd_sel[3:2], F_stall); end
    E_is_load = 1; E_RegWrite = 1; E_rd = 6; D_rs = {5'd6, 5'd6}; D_rs_used = 2'b00;
    #1;
    tests++; if (F_stall !== 1'b0) begin fails++; $display("FAIL lu_unused got %b exp 0", F_stall); end
    E_rd = 0; D_rs = '0; D_rs_used = 2'b11;
    #1;
    tests++; if (F_stall !== 1'b0) begin fails++; $display("FAIL lu_x0 got %b exp 0", F_stall); end
    idle();
    tick();
  endtask

  task automatic test_redirect;
    idle();
    E_is_load = 1; E_RegWrite = 1; E_rd = 6; D_rs = {5'd0, 5'd6}; D_rs_used = 2'b01; E_PCSrc = 1;
    #1;
    tests++; if ({D_flush, E_flush, F_stall, D_stall} !== 4'b1100) begin fails++; $display("FAIL redir_over_lu got %b exp 1100", {D_flush, E_flush, F_stall, D_stall}); end
    tick();
    tests++; if (flush_events !== 4'd1 || stall_cycles !== 4'd1) begin fails++; $display("FAIL redir_cnt got %0d/%0d exp 1/1", flush_events, stall_cycles); end
    idle();
    tick();
  endtask

  task automatic test_mem_wait;
    idle();
    M_mem_req = 1; mem_ready = 0; E_PCSrc = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++; if ({F_stall, D_stall, E_stall, M_stall, W_bubble, D_flush, E_flush} !== 7'b1111100) begin fails++; $display("FAIL mw_cycle%0d got %b exp 1111100", c, {F_stall, D_stall, E_stall, M_stall, W_bubble, D_flush, E_flush}); end
      tick();
    end
    mem_ready = 1;
    #1;
    tests++; if ({D_flush, E_flush, F_stall, W_bubble} !== 4'b1100) begin fails++; $display("FAIL mw_release got %b exp 1100", {D_flush, E_flush, F_stall, W_bubble}); end
    tick();
    tests++; if (wait_cycles !== 4'd3 || flush_events !== 4'd2 || stall_cycles !== 4'd4) begin fails++; $display("FAIL mw_cnt got %0d/%0d/%0d exp 3/2/4", wait_cycles, flush_events, stall_cycles); end
    tests++; if (mem_timeout !== 1'b0) begin fails++; $display("FAIL mw_no_timeout got %b exp 0", mem_timeout); end
    idle();
    tick();
  endtask

  task automatic test_timeout;
    idle();
    M_mem_req = 1;
    for (int c = 0; c < 3; c++) tick();
    tests++; if (mem_timeout !== 1'b0) begin fails++; $display("FAIL to_early got %b exp 0", mem_timeout); end
    for (int c = 0; c < 3; c++) tick();
    tests++; if (mem_timeout !== 1'b1) begin fails++; $display("FAIL to_set got %b exp 1", mem_timeout); end
    mem_ready = 1;
    tick();
    tests++; if (mem_timeout !== 1'b1) begin fails++; $display("FAIL to_sticky got %b exp 1", mem_timeout); end
    tests++; if (stall_cycles !== 4'd10 || wait_cycles !== 4'd9) begin fails++; $display("FAIL to_cnt got %0d/%0d exp 10/9", stall_cycles, wait_cycles); end
    mem_ready = 0; clear_counters = 1;
    tick();
    tests++; if ({stall_cycles, flush_events, wait_cycles, mem_timeout} !== 13'd0) begin fails++; $display("FAIL clear got %h exp 0", {stall_cycles, flush_events, wait_cycles, mem_timeout}); end
    idle();
    tick();
  endtask

  task automatic test_saturate;
    idle();
    E_is_load = 1; E_RegWrite = 1; E_rd = 3; D_rs = {5'd0, 5'd3}; D_rs_used = 2'b01;
    for (int c = 0; c < 15; c++) tick();
    tests++; if (stall_cycles !== 4'd15) begin fails++; $display("FAIL sat_reach got %0d exp 15", stall_cycles); end
    for (int c = 0; c < 5; c++) tick();
    tests++; if (stall_cycles !== 4'd15) begin fails++; $display("FAIL sat_hold got %0d exp 15", stall_cycles); end
    idle();
  endtask

  task automatic test_reset_mid_wait;
    idle();
    M_mem_req = 1;
    tick();
    tick();
    tests++; if (wait_cycles !== 4'd2) begin fails++; $display("FAIL rmw_wait got %0d exp 2", wait_cycles); end
    rst = 0;
    #1;
    tests++; if ({D_flush, E_flush, F_stall, M_stall, W_bubble} !== 5'b11000) begin fails++; $display("FAIL rmw_outs got %b exp 11000", {D_flush, E_flush, F_stall, M_stall, W_bubble}); end
    tick();
    tests++; if ({stall_cycles, flush_events, wait_cycles, mem_timeout} !== 13'd0) begin fails++; $display("FAIL rmw_cnt got %h exp 0", {stall_cycles, flush_events, wait_cycles, mem_timeout}); end
    rst = 1;
    for (int c = 0; c < 3; c++) tick();
    tests++; if (mem_timeout !== 1'b0 || wait_cycles !== 4'd3) begin fails++; $display("FAIL rmw_restart got %b/%0d exp 0/3", mem_timeout, wait_cycles); end
    idle();
    tick();
  endtask

  initial begin
    rst = 0;
    idle();
    test_reset();
    test_forward();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_timeout();
    test_saturate();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised successor to the pipeline's forwarding-only hazard logic. Sits beside the F/D/E/M/W pipeline registers.
- Generates per-source forwarding selects for NUM_SRC execute operands, load-use stalls, branch/jump flushes, and multi-cycle data-memory wait stalls.
- Tracks wait, stall and flush activity in saturating counters, with a sticky memory-timeout flag.

Parameters:
- ADDR_WIDTH, 5, register-address width.
- NUM_SRC, 2, number of source operands per instruction.
- CNT_WIDTH, 16, width of the performance counters and the wait counter.
- MEM_TIMEOUT, 64, number of consecutive memory-wait cycles that sets mem_timeout.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- D_rs  in  NUM_SRC*ADDR_WIDTH  decode-stage source addresses; source i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- D_rs_used  in  NUM_SRC  decode source i is actually read.
- E_rs  in  NUM_SRC*ADDR_WIDTH  execute-stage source addresses, same packing as D_rs.
- E_rd  in  ADDR_WIDTH  execute-stage destination register.
- E_RegWrite  in  1  execute-stage instruction writes a register.
- E_is_load  in  1  execute-stage instruction is a load (result_src==01).
- E_PCSrc  in  1  execute-stage redirect (branch taken or jump).
- M_rd, M_RegWrite, M_is_load  in  ADDR_WIDTH/1/1  memory-stage equivalents.
- W_rd, W_RegWrite  in  ADDR_WIDTH/1  writeback-stage equivalents.
- M_mem_req  in  1  memory-stage instruction accesses data memory this cycle.
- mem_ready  in  1  data memory completes the access this cycle.
- clear_counters  in  1  synchronous clear of all counters and of mem_timeout.
- fwd_sel  out  2*NUM_SRC  per-source select: 00 register file, 01 M ALU result, 10 W result.
- F_stall, D_stall, E_stall, M_stall  out  1  hold the corresponding pipeline register.
- D_flush, E_flush  out  1  load a bubble into D or E.
- W_bubble  out  1  suppress the writeback-register update.
- stall_cycles, flush_events, wait_cycles  out  CNT_WIDTH  saturating counters.
- mem_timeout  out  1  sticky error flag.

Behaviour:
- Register address 0 never matches for forwarding or hazard purposes.
- Forwarding (combinational), per source i:
  - 01 if M_RegWrite && !M_is_load && M_rd==E_rs[i]
  - else 10 if W_RegWrite && W_rd==E_rs[i]
  - else 00.
  - M beats W when both match.
- Load-use hazard (lu): E_is_load && E_RegWrite && some i has D_rs_used[i] && D_rs[i]==E_rd.
  - Response: F_stall=1, D_stall=1, E_flush=1. Exactly one bubble; the dependent instruction then takes its operand via W forwarding.
- Redirect: E_PCSrc=1 gives D_flush=1 and E_flush=1.
  - Redirect overrides lu: if both, F_stall=0 and D_stall=0.
- Memory wait (mw): M_mem_req && !mem_ready.
  - Response: F_stall=D_stall=E_stall=M_stall=1, W_bubble=1, D_flush=E_flush=0.
  - lu and E_PCSrc are ignored while mw is asserted; the branch stays held in E and redirects after the wait.
  - mw has top priority. Asserted in the same cycle as the request (no added latency).
- Wait FSM (registered):
  - RUN -> WAIT on mw.
  - WAIT -> RUN on mem_ready, or when M_mem_req drops.
  - Wait counter: cleared on entry to RUN, +1 per WAIT cycle.
  - When the counter reaches MEM_TIMEOUT-1 while still in WAIT, mem_timeout sets and stays set.
  - The FSM does not alter stall outputs; it only times the wait.
- Counters (saturate at all-ones, never wrap):
  - stall_cycles +1 each cycle F_stall=1.
  - flush_events +1 per cycle with unmasked E_PCSrc (once per redirect).
  - wait_cycles +1 per mw cycle.
- clear_counters zeroes the counters and mem_timeout next edge; if clear and increment coincide, the counter becomes 0.
- Reset (rst==0 at rising edge): state RUN, all counters 0, mem_timeout 0.
- While rst==0, outputs are forced:
  - fwd_sel=0, all stalls 0, W_bubble=0
  - D_flush=1, E_flush=1 (pipeline fills with bubbles).
- Reset mid-wait returns to RUN with no timeout.

Test Plan:
- add x5 in M (M_RegWrite=1, M_rd=5), dependent E_rs[0]=5 with W_rd=5 also writing -> fwd_sel[1:0]=01. Drop M_RegWrite -> 10. Set E_rs[0]=0 with M_rd=0 -> 00.
- E: lw x6 (E_is_load=1, E_rd=6). D: D_rs[1]=6, D_rs_used[1]=1 -> one cycle of F_stall=D_stall=E_flush=1, stall_cycles=1. Next cycle, with the load in W, E_rs[1]=6 -> fwd_sel[3:2]=10.
- E_PCSrc=1 together with a load-use condition -> D_flush=E_flush=1, F_stall=0, flush_events increments by 1.
- M_mem_req=1, mem_ready=0 for 3 cycles, then 1, with E_PCSrc=1 throughout:
  - 3 cycles: F/D/E/M_stall=1, W_bubble=1, no flush.
  - Cycle 4: D_flush=E_flush=1.
  - wait_cycles=3.
- MEM_TIMEOUT=4, mem_ready held 0 for 6 cycles -> mem_timeout=1 after 4 wait cycles and stays 1 after mem_ready. clear_counters -> 0.
- CNT_WIDTH=4, 20 load-use stalls -> stall_cycles saturates at 15. Drive rst=0 mid-wait -> next cycle all counters 0, state RUN, D_flush=E_flush=1 while rst is low.
